// File: rtl/board_cell_writer.sv
// Write side of the 4x4 game board: owns the cell registers, validates and performs
// place requests for the current player, and supports a whole-board clear.
module board_cell_writer #(
  parameter int unsigned     NCELLS  = 16,
  parameter int unsigned     CW      = 4,
  parameter logic [CW-1:0]   P1_CODE = 'b0001,
  parameter logic [CW-1:0]   P2_CODE = 'b0010
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           sel,
  input  logic                 place_req,
  input  logic                 clear_req,
  output logic [NCELLS*CW-1:0] cells,
  output logic                 turn,
  output logic                 busy,
  output logic                 place_ok,
  output logic                 place_err,
  output logic [4:0]           moves,
  output logic                 full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_ERR,
    S_CLEAR
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            sel_q, sel_d;
  logic [NCELLS*CW-1:0]  cells_q, cells_d;
  logic                  turn_q, turn_d;
  logic                  busy_q, busy_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
  logic [4:0]            moves_q, moves_d;

  logic [CW-1:0]         cell_sel;
  logic                  sel_valid;
  logic                  cell_empty;
  logic                  full_w;

  assign full_w = (moves_q == 5'(NCELLS));

  always_comb begin
    cell_sel = '0;
    for (int unsigned k = 0; k < NCELLS; k++) begin
      if (32'(sel_q) == k) cell_sel = cells_q[CW*k +: CW];
    end
    sel_valid  = (32'(sel_q) < NCELLS);
    cell_empty = (cell_sel == '0) || (cell_sel == '1);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cells_d = cells_q;
    turn_d  = turn_q;
    moves_d = moves_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    // busy trails the state by one edge so it spans edges N+1..N+3 of a placement
    busy_d  = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
        end else if (place_req) begin
          sel_d   = sel;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        state_d = (sel_valid && cell_empty && !full_w) ? S_WRITE : S_ERR;
      end
      S_WRITE: begin
        for (int unsigned k = 0; k < NCELLS; k++) begin
          if (32'(sel_q) == k) cells_d[CW*k +: CW] = turn_q ? P2_CODE : P1_CODE;
        end
        if (!full_w) moves_d = moves_q + 5'd1;
        turn_d  = ~turn_q;
        ok_d    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        cells_d = '0;
        moves_d = '0;
        turn_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cells_q <= '0;
      turn_q  <= 1'b0;
      busy_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      moves_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cells_q <= cells_d;
      turn_q  <= turn_d;
      busy_q  <= busy_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      moves_q <= moves_d;
    end
  end

  assign cells     = cells_q;
  assign turn      = turn_q;
  assign busy      = busy_q;
  assign place_ok  = ok_q;
  assign place_err = err_q;
  assign moves     = moves_q;
  assign full      = full_w;

endmodule

// File: tb/tb_board_cell_writer.sv
// Bench for board_cell_writer: table of place requests checked against a board model
// through an expectation queue, plus hand-written clear, busy and reset sequences.
module tb_board_cell_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  sel;
  logic        place_req;
  logic        clear_req;
  logic [63:0] cells;
  logic        turn;
  logic        busy;
  logic        place_ok;
  logic        place_err;
  logic [4:0]  moves;
  logic        full;

  board_cell_writer #(.NCELLS(16), .CW(4), .P1_CODE(4'b0001), .P2_CODE(4'b0010)) dut (
    .clk(clk), .rst(rst), .sel(sel), .place_req(place_req), .clear_req(clear_req),
    .cells(cells), .turn(turn), .busy(busy), .place_ok(place_ok), .place_err(place_err),
    .moves(moves), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [3:0] m_cell [16];
  logic       m_turn;
  int         m_moves;

  typedef struct {
    logic        ok;
    logic        err;
    logic [63:0] cells;
    logic        turn;
    logic [4:0]  moves;
    logic        full;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0] sel;
    logic       ok;
  } vec_t;
  vec_t tv[$];

  function automatic logic [63:0] m_pack();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[4*k +: 4] = m_cell[k];
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 16; k++) m_cell[k] = 4'b0000;
    m_turn  = 1'b0;
    m_moves = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic chk_state(input string name);
    chk({name, "_cells"}, cells, m_pack());
    chk({name, "_turn"}, 64'(turn), 64'(m_turn));
    chk({name, "_moves"}, 64'(moves), 64'(m_moves));
    chk({name, "_full"}, 64'(full), 64'(m_moves == 16));
  endtask

  task automatic quiet_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(name, 64'({place_ok, place_err}), 64'(0));
    end
  endtask

  task automatic apply_place(input logic [7:0] s, input logic exp_ok, input logic inject);
    exp_t e;
    int   w;
    @(negedge clk);
    sel = s; place_req = 1'b1;
    @(posedge clk); #1;
    if (!inject) place_req = 1'b0;
    clear_req = inject;
    sel = 8'($urandom_range(0, 255));
    if (exp_ok) begin
      m_cell[s[3:0]] = m_turn ? 4'b0010 : 4'b0001;
      m_moves++;
      m_turn = ~m_turn;
    end
    e.ok = exp_ok; e.err = !exp_ok; e.cells = m_pack(); e.turn = m_turn;
    e.moves = 5'(m_moves); e.full = (m_moves == 16);
    sbq.push_back(e);
    @(posedge clk); #1;
    place_req = 1'b0; clear_req = 1'b0;
    chk("busy_n1", 64'(busy), 64'(1));
    chk("no_pulse_n1", 64'({place_ok, place_err}), 64'(0));
    w = 1;
    @(posedge clk); #1;
    while (!(place_ok | place_err) && w < 5) begin
      @(posedge clk); #1;
      w++;
    end
    if (!(place_ok | place_err)) begin
      checks++; errors++;
      $display("FAIL pulse_timeout: got no pulse for sel=%0d required one within 5 cycles", s);
      void'(sbq.pop_front());
    end else begin
      e = sbq.pop_front();
      chk("latency", 64'(w), 64'(1));
      chk("ok", 64'(place_ok), 64'(e.ok));
      chk("err", 64'(place_err), 64'(e.err));
      chk("cells", cells, e.cells);
      chk("turn", 64'(turn), 64'(e.turn));
      chk("moves", 64'(moves), 64'(e.moves));
      chk("full", 64'(full), 64'(e.full));
    end
    @(posedge clk); #1;
    chk("pulse_end", 64'({place_ok, place_err}), 64'(0));
    chk("busy_end", 64'(busy), 64'(0));
    if (inject) begin
      quiet_cycles("busy_ignored", 3);
      chk_state("busy_ignored");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel = '0; place_req = 1'b0; clear_req = 1'b0;
    m_reset();

    tv.push_back('{8'd5, 1'b1});
    tv.push_back('{8'd5, 1'b0});
    tv.push_back('{8'd3, 1'b1});
    tv.push_back('{8'd16, 1'b0});
    tv.push_back('{8'd200, 1'b0});
    for (int k = 0; k < 16; k++) if (k != 3 && k != 5) tv.push_back('{8'(k), 1'b1});
    tv.push_back('{8'd0, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    chk_state("reset");
    chk("reset_busy", 64'({busy, place_ok, place_err}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tv.size(); i++) begin
      if (i == 2) begin
        // cell 3 holds 1111, which still counts as empty
        @(negedge clk);
        m_cell[3] = 4'hF;
        force dut.cells_q = m_pack();
        #1;
        release dut.cells_q;
        @(posedge clk); #1;
        chk("preload", 64'(cells[15:12]), 64'(4'hF));
      end
      apply_place(tv[i].sel, tv[i].ok, 1'b0);
    end
    chk_state("filled");

    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    m_reset();
    quiet_cycles("clear_no_pulse", 2);
    chk_state("cleared");

    apply_place(8'd7, 1'b1, 1'b0);
    @(negedge clk);
    clear_req = 1'b1; place_req = 1'b1; sel = 8'd9;
    @(posedge clk); #1;
    clear_req = 1'b0; place_req = 1'b0;
    m_reset();
    quiet_cycles("clear_prio", 3);
    chk_state("clear_prio");

    apply_place(8'd9, 1'b1, 1'b1);

    @(negedge clk);
    sel = 8'd11; place_req = 1'b1;
    @(posedge clk); #1;
    place_req = 1'b0;
    rst = 1'b1;
    #1;
    m_reset();
    chk_state("rst_check");
    chk("rst_check_flags", 64'({busy, place_ok, place_err}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    quiet_cycles("rst_no_pulse", 4);
    chk_state("rst_after");

    apply_place(8'd11, 1'b1, 1'b0);
    chk("sbq_empty", 64'(sbq.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
